// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and helpers for the FFT frame sequencer: controller states,
// FFT config word field widths, sample/bin/magnitude widths and small
// combinational helpers used on the output-beat path.
package fft_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONFIG = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } seq_state_t;

    // FFT config word layout: {pad, scale schedule, forward flag}
    localparam int CFG_PAD_W   = 1;
    localparam int CFG_SCALE_W = 6;
    localparam int CFG_FWD_W   = 1;
    localparam int CFG_TDATA_W = CFG_PAD_W + CFG_SCALE_W + CFG_FWD_W;

    localparam int SAMPLE_W = 10;
    localparam int BIN_W    = 6;
    localparam int MAG_W    = 11;

    // Reverse the low nbits of idx; upper bits of idx are expected to be zero.
    function automatic logic [BIN_W-1:0] bit_rev(input logic [BIN_W-1:0] idx,
                                                 input int nbits);
        logic [BIN_W-1:0] r;
        for (int i = 0; i < BIN_W; i++) begin
            r[i] = idx[BIN_W-1-i];
        end
        return r >> (BIN_W - nbits);
    endfunction

    // |re| + |im| of two signed 10-bit values; |-512| is 512 as unsigned.
    function automatic logic [MAG_W-1:0] l1_mag(input logic [SAMPLE_W-1:0] re,
                                                input logic [SAMPLE_W-1:0] im);
        logic [SAMPLE_W-1:0] are;
        logic [SAMPLE_W-1:0] aim;
        are = re[SAMPLE_W-1] ? -re : re;
        aim = im[SAMPLE_W-1] ? -im : im;
        return {1'b0, are} + {1'b0, aim};
    endfunction

endpackage

// File: rtl/sample_skid_fifo.sv
// Small synchronous FIFO buffering SPI samples ahead of the FFT input
// channel. A push on a full FIFO only lands if a pop happens in the same
// cycle; otherwise the sample is dropped (caller flags the overflow).
module sample_skid_fifo
    import fft_frame_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == COUNT_FULL);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// FFT frame sequencer: configures the FFT core once per enable, streams one
// frame of buffered SPI samples into it, scans the returned spectrum for the
// strongest bin inside a search window and raises a trigger when it clears
// the threshold.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | search disabled, waiting for enable
// CONFIG | presenting the FFT config word until the core accepts it
// STREAM | forwarding FRAME_LEN samples from the FIFO to the FFT input
// DRAIN  | consuming FFT output beats, tracking the windowed peak
// REPORT | one cycle: peak published, trigger pulsed if above threshold
module fft_frame_sequencer
    import fft_frame_sequencer_pkg::*;
#(
    parameter int                 FRAME_LEN   = 64,
    parameter logic [CFG_SCALE_W-1:0] SCALE_SCHED = 6'b101011,
    parameter int                 BIN_LO      = 1,
    parameter int                 BIN_HI      = 31,
    parameter logic [MAG_W-1:0]   THRESH      = 11'd64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sample_valid,
    input  logic [SAMPLE_W-1:0]    sample_data,
    output logic                   cfg_tvalid,
    output logic [CFG_TDATA_W-1:0] cfg_tdata,
    input  logic                   cfg_tready,
    output logic                   s_tvalid,
    output logic [31:0]            s_tdata,
    output logic                   s_tlast,
    input  logic                   s_tready,
    input  logic                   m_tvalid,
    input  logic [31:0]            m_tdata,
    input  logic [15:0]            m_tuser,
    input  logic                   m_tlast,
    output logic                   m_tready,
    input  logic                   evt_tlast_unexpected,
    input  logic                   evt_tlast_missing,
    output logic                   trigger,
    output logic [BIN_W-1:0]       peak_bin,
    output logic [MAG_W-1:0]       peak_mag,
    output logic                   busy,
    output logic                   overflow,
    output logic                   frame_error
);

    localparam int               LOG2_LEN  = $clog2(FRAME_LEN);
    localparam logic [BIN_W-1:0] LAST_BEAT = BIN_W'(FRAME_LEN - 1);
    localparam logic [BIN_W-1:0] WIN_LO    = BIN_W'(BIN_LO);
    localparam logic [BIN_W-1:0] WIN_HI    = BIN_W'(BIN_HI);

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [BIN_W-1:0]    beat_cnt;
    logic [BIN_W-1:0]    out_cnt;
    logic [MAG_W-1:0]    run_max;
    logic [MAG_W-1:0]    run_max_nxt;
    logic [BIN_W-1:0]    run_bin;
    logic [BIN_W-1:0]    run_bin_nxt;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [SAMPLE_W-1:0] fifo_head;

    logic                m_beat;
    logic                last_in_beat;
    logic                tlast_absent;
    logic                report_load;
    logic [BIN_W-1:0]    beat_bin;
    logic [MAG_W-1:0]    beat_mag;
    logic                in_window;
    logic                beat_wins;
    logic                unused_bits;

    sample_skid_fifo #(
        .DEPTH (4),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sample_data),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign fifo_push = sample_valid & (state != IDLE);
    assign s_tvalid  = (state == STREAM) & ~fifo_empty;
    assign fifo_pop  = s_tvalid & s_tready;
    assign s_tdata   = {16'h0, {(16 - SAMPLE_W){fifo_head[SAMPLE_W-1]}}, fifo_head};
    assign s_tlast   = s_tvalid & (beat_cnt == LAST_BEAT);
    assign cfg_tdata = {1'b0, SCALE_SCHED, 1'b1};
    assign busy      = (state != IDLE);

    assign m_beat    = m_tvalid & m_tready;
    assign beat_bin  = bit_rev(m_tuser[BIN_W-1:0], LOG2_LEN);
    assign beat_mag  = l1_mag(m_tdata[SAMPLE_W-1:0], m_tdata[16+SAMPLE_W-1:16]);
    assign in_window = (beat_bin >= WIN_LO) & (beat_bin <= WIN_HI);
    // ties go to the lower bin regardless of arrival order
    assign beat_wins = in_window &
                       ((beat_mag > run_max) | ((beat_mag == run_max) & (beat_bin < run_bin)));

    assign unused_bits = ^{m_tuser[15:BIN_W], m_tdata[31:16+SAMPLE_W], m_tdata[15:SAMPLE_W]};

    // next-state and per-state handshake outputs
    always_comb begin
        state_nxt    = state;
        cfg_tvalid   = 1'b0;
        m_tready     = 1'b0;
        last_in_beat = 1'b0;
        tlast_absent = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = CONFIG;
            end
            CONFIG: begin
                cfg_tvalid = 1'b1;
                if (cfg_tready) state_nxt = STREAM;
            end
            STREAM: begin
                if (fifo_pop && (beat_cnt == LAST_BEAT)) begin
                    last_in_beat = 1'b1;
                    state_nxt    = DRAIN;
                end
            end
            DRAIN: begin
                m_tready = 1'b1;
                if (m_tvalid) begin
                    if (m_tlast) begin
                        state_nxt = REPORT;
                    end else if (out_cnt == LAST_BEAT) begin
                        tlast_absent = 1'b1;
                        state_nxt    = REPORT;
                    end
                end
            end
            REPORT: begin
                state_nxt = enable ? STREAM : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign report_load = (state == DRAIN) & (state_nxt == REPORT);

    // running peak including the beat currently on the output channel
    always_comb begin
        run_max_nxt = run_max;
        run_bin_nxt = run_bin;
        if (m_beat && beat_wins) begin
            run_max_nxt = beat_mag;
            run_bin_nxt = beat_bin;
        end
    end

    // controller state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // beat counters and running peak, cleared on DRAIN entry
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            out_cnt  <= '0;
            run_max  <= '0;
            run_bin  <= '0;
        end else begin
            if (fifo_pop) begin
                beat_cnt <= last_in_beat ? '0 : beat_cnt + BIN_W'(1);
            end
            if (last_in_beat) begin
                out_cnt <= '0;
                run_max <= '0;
                run_bin <= '0;
            end else if (m_beat) begin
                out_cnt <= out_cnt + BIN_W'(1);
                run_max <= run_max_nxt;
                run_bin <= run_bin_nxt;
            end
        end
    end

    // published peak, trigger/overflow pulses and sticky frame error
    always_ff @(posedge clk) begin
        if (reset) begin
            trigger     <= 1'b0;
            peak_bin    <= '0;
            peak_mag    <= '0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            trigger  <= report_load & (run_max_nxt >= THRESH);
            overflow <= fifo_push & fifo_full & ~fifo_pop;
            if (report_load) begin
                peak_bin <= run_bin_nxt;
                peak_mag <= run_max_nxt;
            end
            if (evt_tlast_unexpected || evt_tlast_missing || tlast_absent) begin
                frame_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for the FFT frame sequencer: config handshake, sample
// streaming, peak search over hand-built spectra, FIFO overflow and reset.
module tb_fft_frame_sequencer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        sample_valid;
    logic [9:0]  sample_data;
    logic        cfg_tvalid;
    logic [7:0]  cfg_tdata;
    logic        cfg_tready;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic [15:0] m_tuser;
    logic        m_tlast;
    logic        m_tready;
    logic        evt_tlast_unexpected;
    logic        evt_tlast_missing;
    logic        trigger;
    logic [5:0]  peak_bin;
    logic [10:0] peak_mag;
    logic        busy;
    logic        overflow;
    logic        frame_error;

    int total = 0;
    int bad   = 0;

    logic [15:0] re_v [64];
    logic [15:0] im_v [64];
    logic [9:0]  ov_vals [5];

    fft_frame_sequencer dut (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .sample_valid         (sample_valid),
        .sample_data          (sample_data),
        .cfg_tvalid           (cfg_tvalid),
        .cfg_tdata            (cfg_tdata),
        .cfg_tready           (cfg_tready),
        .s_tvalid             (s_tvalid),
        .s_tdata              (s_tdata),
        .s_tlast              (s_tlast),
        .s_tready             (s_tready),
        .m_tvalid             (m_tvalid),
        .m_tdata              (m_tdata),
        .m_tuser              (m_tuser),
        .m_tlast              (m_tlast),
        .m_tready             (m_tready),
        .evt_tlast_unexpected (evt_tlast_unexpected),
        .evt_tlast_missing    (evt_tlast_missing),
        .trigger              (trigger),
        .peak_bin             (peak_bin),
        .peak_mag             (peak_mag),
        .busy                 (busy),
        .overflow             (overflow),
        .frame_error          (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] rev6(input logic [5:0] x);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[5-i] = x[i];
        return r;
    endfunction

    function automatic logic [31:0] sext32(input logic [9:0] v);
        return {16'h0, {6{v[9]}}, v};
    endfunction

    task automatic fill(input logic [15:0] re, input logic [15:0] im);
        for (int b = 0; b < 64; b++) begin
            re_v[b] = re;
            im_v[b] = im;
        end
    endtask

    // push a 0..63 ramp and check the 64 beats that reach the FFT input
    task automatic feed_frame(input string tag);
        int sent = 0;
        int beats = 0;
        int derr = 0;
        int lasts = 0;
        int last_pos = -1;
        int cyc = 0;
        s_tready = 1'b1;
        while (beats < 64 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (s_tvalid && s_tready) begin
                if (s_tdata !== 32'(beats)) derr++;
                if (s_tlast) begin
                    lasts++;
                    last_pos = beats;
                end
                beats++;
            end
            if (sent < 64) begin
                sample_valid = 1'b1;
                sample_data  = 10'(sent);
                sent++;
            end else begin
                sample_valid = 1'b0;
            end
        end
        sample_valid = 1'b0;
        chk({tag, "_s_beats"}, beats, 64);
        chk({tag, "_s_data_err"}, derr, 0);
        chk({tag, "_s_tlast_cnt"}, lasts, 1);
        chk({tag, "_s_tlast_pos"}, last_pos, 63);
    endtask

    // play re_v/im_v out in bit-reversed order and check the report cycle
    task automatic out_frame(input string tag, input logic with_tlast,
                             input logic [5:0] exp_bin, input logic [10:0] exp_mag,
                             input logic exp_trig, input logic exp_ferr);
        int w = 0;
        logic [5:0] b;
        while (!m_tready && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_drain_entry"}, m_tready, 1);
        for (int k = 0; k < 64; k++) begin
            if (k > 0) @(negedge clk);
            b        = rev6(6'(k));
            m_tvalid = 1'b1;
            m_tuser  = {10'h0, 6'(k)};
            m_tdata  = {im_v[b], re_v[b]};
            m_tlast  = with_tlast && (k == 63);
        end
        @(negedge clk);
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        chk({tag, "_trigger"}, trigger, exp_trig);
        chk({tag, "_peak_bin"}, peak_bin, exp_bin);
        chk({tag, "_peak_mag"}, peak_mag, exp_mag);
        chk({tag, "_frame_err"}, frame_error, exp_ferr);
        @(negedge clk);
        chk({tag, "_trig_pulse"}, trigger, 0);
    endtask

    initial begin
        int hs;
        int ovf;
        int hold_err;
        int tv_err;
        reset = 1'b1;
        enable = 1'b0;
        sample_valid = 1'b0;
        sample_data = '0;
        cfg_tready = 1'b0;
        s_tready = 1'b1;
        m_tvalid = 1'b0;
        m_tdata = '0;
        m_tuser = '0;
        m_tlast = 1'b0;
        evt_tlast_unexpected = 1'b0;
        evt_tlast_missing = 1'b0;
        ov_vals = '{-10'sd3, 10'd100, -10'sd200, 10'd7, 10'd8};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ctl", {cfg_tvalid, s_tvalid, s_tlast, m_tready, trigger, overflow, frame_error}, 0);
        chk("rst_peak", {peak_bin, peak_mag}, 0);

        // config handshake, ready held low for one cycle first
        reset  = 1'b0;
        enable = 1'b1;
        hs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("cfg_tvalid", cfg_tvalid, 1);
                chk("cfg_tdata", cfg_tdata, 8'h57);
                chk("cfg_busy", busy, 1);
            end
            if (i == 1) cfg_tready = 1'b1;
            if (cfg_tvalid && cfg_tready) hs++;
        end
        chk("cfg_beats", hs, 1);
        chk("cfg_done", cfg_tvalid, 0);

        // frame A: bin 5 at 200, everything else at 10
        feed_frame("frmA");
        fill(-16'sd5, 16'd5);
        re_v[5] = 16'd200;
        im_v[5] = 16'd0;
        out_frame("frmA", 1'b1, 6'd5, 11'd200, 1'b1, 1'b0);
        chk("reentry_nocfg", cfg_tvalid, 0);
        chk("reentry_busy", busy, 1);

        // frame B: tie at 100 on bins 7 and 3, larger values outside window
        feed_frame("frmB");
        fill(16'd0, 16'd0);
        re_v[7]  = 16'd100;
        im_v[3]  = -16'sd100;
        re_v[0]  = -16'sd500;
        re_v[40] = 16'd300;
        out_frame("frmB", 1'b1, 6'd3, 11'd100, 1'b1, 1'b0);

        // frame C: peak one below threshold on the upper window edge
        feed_frame("frmC");
        fill(16'd1, 16'd1);
        re_v[31] = -16'sd60;
        im_v[31] = 16'd3;
        re_v[32] = 16'd400;
        out_frame("frmC", 1'b1, 6'd31, 11'd63, 1'b0, 1'b0);

        // frame D: enable dropped mid-frame, no m_tlast, -512 on lower edge
        enable = 1'b0;
        feed_frame("frmD");
        fill(16'd0, 16'd0);
        re_v[1] = -16'sd512;
        im_v[1] = 16'd1;
        out_frame("frmD", 1'b0, 6'd1, 11'd513, 1'b1, 1'b1);
        chk("idle_after_disable", busy, 0);

        // overflow: five samples with the FFT input stalled
        enable   = 1'b1;
        s_tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ovf = 0;
        hold_err = 0;
        tv_err = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (overflow) ovf++;
            if (i >= 1) begin
                if (s_tdata !== 32'h0000FFFD) hold_err++;
                if (s_tvalid !== 1'b1) tv_err++;
            end
            if (i < 5) begin
                sample_valid = 1'b1;
                sample_data  = ov_vals[i];
            end else begin
                sample_valid = 1'b0;
            end
        end
        chk("ovf_pulses", ovf, 1);
        chk("ovf_hold", hold_err, 0);
        chk("ovf_tvalid", tv_err, 0);
        s_tready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("ovf_pop%0d", j), s_tdata, sext32(ov_vals[j]));
            @(negedge clk);
        end
        chk("ovf_depth4", s_tvalid, 0);

        // reset in the middle of STREAM with a sample pending
        s_tready     = 1'b0;
        sample_valid = 1'b1;
        sample_data  = 10'd9;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("pre_rst_tvalid", s_tvalid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_ctl", {cfg_tvalid, s_tvalid, s_tlast, m_tready, trigger, overflow, frame_error}, 0);
        chk("midrst_peak", {peak_bin, peak_mag}, 0);
        reset  = 1'b0;
        enable = 1'b0;

        // core event inputs set the sticky frame error
        @(negedge clk);
        evt_tlast_unexpected = 1'b1;
        @(negedge clk);
        evt_tlast_unexpected = 1'b0;
        chk("evt_unexp", frame_error, 1);
        @(negedge clk);
        chk("evt_sticky", frame_error, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("evt_cleared", frame_error, 0);
        evt_tlast_missing = 1'b1;
        @(negedge clk);
        evt_tlast_missing = 1'b0;
        chk("evt_missing", frame_error, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
